// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter: one shared resource, 16 level-held requesters, with a bounded hold time.
// Latency: a request seen in IDLE is granted after one edge. A released grant is followed by one dead RELEASE cycle.
// Backpressure: req is held by the requester until served. Requests raised during GRANT/RELEASE wait for IDLE.
//
// Ports: clk, rst (async active-high); req[15:0] level requests; done release pulse from owner;
//        grant_en/grant_idx registered owner; grant one-hot decode of them; busy (GRANT or RELEASE);
//        timeout 1-cycle pulse when the hold limit forces a release.

module decoder_4_to_16 (
    input  logic        en,
    input  logic [3:0]  a,
    output logic [15:0] y
);
    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end
endmodule

module rr_arbiter_16 #(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic        grant_en,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant,
    output logic        busy,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam bit              USE_LIMIT  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = USE_LIMIT ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state;
    logic [3:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        winner;
    logic              hold_hit;
    logic              owner_req;
    logic              release_now;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner = '0;
        for (int k = 15; k >= 0; k--) begin
            if (req[ptr + 4'(k)]) winner = ptr + 4'(k);
        end
    end

    assign hold_hit    = USE_LIMIT && (hold_cnt == HOLD_LIMIT);
    assign owner_req   = req[grant_idx];
    assign release_now = done || !owner_req || hold_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant_en  <= 1'b0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        grant_idx <= winner;
                        grant_en  <= 1'b1;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                    if (release_now) begin
                        grant_en <= 1'b0;
                        ptr      <= grant_idx + 4'd1;
                        // Only a genuine forced release flags timeout; done or withdrawal win.
                        timeout  <= hold_hit && !done && owner_req;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    grant_en <= 1'b0;
                    busy     <= 1'b0;
                    timeout  <= 1'b0;
                end
            endcase
        end
    end

    decoder_4_to_16 u_dec (
        .en (grant_en),
        .a  (grant_idx),
        .y  (grant)
    );
endmodule
